// File: rtl/m3ds_sram_bank_array.sv
// Banked single-port SRAM behind an AHB2SRAM-style interface, with optional post-reset zero scrub.
// Latency: read data/valid 1 cycle after request (RD_PIPE=0) or 2 cycles (RD_PIPE=1); writes commit at the request edge.
// Backpressure: none in RUN (one access per cycle). During scrub SRAMREADY=0; accesses are dropped and flagged sticky on SRAMIGNERR.
module m3ds_sram_bank_array #(
    parameter int AW        = 13,
    parameter int NUM_BANKS = 2,
    parameter int RD_PIPE   = 0,
    parameter int INIT_EN   = 1
) (
    input  logic          SRAMHCLK,
    input  logic          SRAMHRESETn,
    input  logic [AW-1:0] SRAMADDR,
    input  logic [3:0]    SRAMWREN,
    input  logic [31:0]   SRAMWDATA,
    input  logic          SRAMCS,
    output logic [31:0]   SRAMRDATA,
    output logic          SRAMRVALID,
    output logic          SRAMREADY,
    output logic          SRAMIGNERR
);

    // Bank-index width; a single-bank build still carries a 1-bit (constant zero) index.
    localparam int BSW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int SW    = (BSW > 0) ? BSW : 1;
    localparam int BAW   = AW - BSW;
    localparam int DEPTH = 1 << BAW;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BAW-1:0]  r_cnt;
    logic            w_ready;
    logic            w_scrub;

    logic [SW-1:0]   w_bank;
    logic [BAW-1:0]  w_row;
    logic            w_acc;
    logic            w_rd;
    logic            w_wr;

    logic [SW-1:0]   r_sel_q;
    logic            r_vld1;
    logic            r_ignerr;
    logic [31:0]     w_dout [NUM_BANKS];
    logic [31:0]     w_mux;

    // Address split: upper bits pick the bank, lower bits the row inside it.
    generate
        if (BSW > 0) begin : g_bank_idx
            assign w_bank = SRAMADDR[AW-1:BAW];
        end else begin : g_bank_one
            assign w_bank = '0;
        end
    endgenerate
    assign w_row = SRAMADDR[BAW-1:0];

    // Accesses only count once scrubbing is done; reset also blocks all array activity.
    assign w_acc = SRAMCS & w_ready & SRAMHRESETn;
    assign w_rd  = w_acc & (SRAMWREN == 4'b0000);
    assign w_wr  = w_acc & (SRAMWREN != 4'b0000);

    // State register: scrub first when enabled, otherwise go straight to RUN.
    always_ff @(posedge SRAMHCLK) begin
        if (!SRAMHRESETn) begin
            r_state <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave INIT on the cycle the last row is written; RUN is terminal.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_cnt == {BAW{1'b1}}) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs: ready in RUN, scrub write strobe in INIT (suppressed while reset is held).
    always_comb begin
        w_ready = 1'b0;
        w_scrub = 1'b0;
        case (r_state)
            ST_RUN:  w_ready = 1'b1;
            ST_INIT: w_scrub = SRAMHRESETn;
            default: w_ready = 1'b0;
        endcase
    end

    // Scrub row counter; wraps to 0 exactly as the FSM leaves INIT.
    always_ff @(posedge SRAMHCLK) begin
        if (!SRAMHRESETn) begin
            r_cnt <= '0;
        end else if (w_scrub) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    genvar gb;
    generate
        for (gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
            logic [31:0] r_mem [DEPTH];
            logic [31:0] r_dout;
            logic        w_ce;

            // Chip enable only for the addressed bank.
            assign w_ce = w_acc & (w_bank == SW'(gb));

            // Array write port: scrub zeroes the same row in every bank; normal writes are byte-masked.
            always_ff @(posedge SRAMHCLK) begin
                if (w_scrub) begin
                    r_mem[r_cnt] <= '0;
                end else if (w_ce && w_wr) begin
                    for (int i = 0; i < 4; i++) begin
                        if (SRAMWREN[i]) r_mem[w_row][8*i +: 8] <= SRAMWDATA[8*i +: 8];
                    end
                end
            end

            // Bank read register; holds its value until this bank is read again.
            always_ff @(posedge SRAMHCLK) begin
                if (!SRAMHRESETn) begin
                    r_dout <= '0;
                end else if (w_ce && w_rd) begin
                    r_dout <= r_mem[w_row];
                end
            end

            assign w_dout[gb] = r_dout;
        end
    endgenerate

    // First read stage: remember which bank answers and flag a result next cycle.
    always_ff @(posedge SRAMHCLK) begin
        if (!SRAMHRESETn) begin
            r_sel_q <= '0;
            r_vld1  <= 1'b0;
        end else begin
            r_vld1 <= w_rd;
            if (w_rd) r_sel_q <= w_bank;
        end
    end

    assign w_mux = w_dout[r_sel_q];

    generate
        if (RD_PIPE != 0) begin : g_pipe
            logic [31:0] r_rdata2;
            logic        r_vld2;

            // Optional output register: capture the muxed result only when a read completes.
            always_ff @(posedge SRAMHCLK) begin
                if (!SRAMHRESETn) begin
                    r_rdata2 <= '0;
                    r_vld2   <= 1'b0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) r_rdata2 <= w_mux;
                end
            end

            assign SRAMRDATA  = r_rdata2;
            assign SRAMRVALID = r_vld2;
        end else begin : g_nopipe
            // Bank registers and select only move on reads, so the mux output already holds between reads.
            assign SRAMRDATA  = w_mux;
            assign SRAMRVALID = r_vld1;
        end
    endgenerate

    // Sticky flag for any access presented before the array is ready.
    always_ff @(posedge SRAMHCLK) begin
        if (!SRAMHRESETn) begin
            r_ignerr <= 1'b0;
        end else if (SRAMCS && !w_ready) begin
            r_ignerr <= 1'b1;
        end
    end

    assign SRAMREADY  = w_ready;
    assign SRAMIGNERR = r_ignerr;

endmodule

// File: tb/tb_m3ds_sram_bank_array.sv
// Directed bench for m3ds_sram_bank_array: default build (scrub on, 2 banks, no output pipe)
// plus a second build with 4 banks, RD_PIPE=1 and no scrub.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_m3ds_sram_bank_array;

    logic        clk = 1'b0;
    logic        rstn;
    logic [12:0] addr;
    logic [3:0]  wren;
    logic [31:0] wdata;
    logic        cs_a;
    logic        cs_b;

    logic [31:0] a_rdata;
    logic        a_rvalid;
    logic        a_ready;
    logic        a_ignerr;
    logic [31:0] b_rdata;
    logic        b_rvalid;
    logic        b_ready;
    logic        b_ignerr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    m3ds_sram_bank_array #(
        .AW(13), .NUM_BANKS(2), .RD_PIPE(0), .INIT_EN(1)
    ) u_dut_a (
        .SRAMHCLK   (clk),
        .SRAMHRESETn(rstn),
        .SRAMADDR   (addr),
        .SRAMWREN   (wren),
        .SRAMWDATA  (wdata),
        .SRAMCS     (cs_a),
        .SRAMRDATA  (a_rdata),
        .SRAMRVALID (a_rvalid),
        .SRAMREADY  (a_ready),
        .SRAMIGNERR (a_ignerr)
    );

    m3ds_sram_bank_array #(
        .AW(13), .NUM_BANKS(4), .RD_PIPE(1), .INIT_EN(0)
    ) u_dut_b (
        .SRAMHCLK   (clk),
        .SRAMHRESETn(rstn),
        .SRAMADDR   (addr),
        .SRAMWREN   (wren),
        .SRAMWDATA  (wdata),
        .SRAMCS     (cs_b),
        .SRAMRDATA  (b_rdata),
        .SRAMRVALID (b_rvalid),
        .SRAMREADY  (b_ready),
        .SRAMIGNERR (b_ignerr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic c, input logic [3:0] we, input logic [12:0] a, input logic [31:0] d);
        cs_a  = c;
        wren  = we;
        addr  = a;
        wdata = d;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cs_a = 1'b0;
        cs_b = 1'b0;
        wren = 4'h0;
        addr = '0;
        wdata = '0;
        repeat (3) tick();
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", a_rdata, 32'h0); end
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", a_rvalid); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", a_ready); end
        checks++; if (a_ignerr !== 1'b0) begin errors++; $display("FAIL reset_ignerr: got %b expected 0", a_ignerr); end
        checks++; if (b_rdata !== 32'h0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_b_out: got %h/%b expected 00000000/0", b_rdata, b_rvalid); end
    endtask

    // Scrub length, plus a write at scrub cycle 100 that must be dropped and flagged.
    task automatic test_scrub_ignore();
        int n;
        n = 0;
        rstn = 1'b1;
        while (a_ready !== 1'b1 && n < 5000) begin
            if (n == 100) drive_a(1'b1, 4'hF, 13'h0005, 32'hFFFF_FFFF);
            else          drive_a(1'b0, 4'h0, 13'h0000, 32'h0);
            tick();
            n++;
            if (n == 1) begin
                checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL noinit_ready: got %b expected 1", b_ready); end
            end
            if (n == 100) begin
                checks++; if (a_ignerr !== 1'b0) begin errors++; $display("FAIL ignerr_before: got %b expected 0", a_ignerr); end
            end
            if (n == 101) begin
                checks++; if (a_ignerr !== 1'b1) begin errors++; $display("FAIL ignerr_set: got %b expected 1", a_ignerr); end
                checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL ignored_no_rvalid: got %b expected 0", a_rvalid); end
            end
        end
        drive_a(1'b0, 4'h0, 13'h0000, 32'h0);
        checks++; if (n !== 4096) begin errors++; $display("FAIL scrub_len: got %0d expected 4096", n); end
        checks++; if (a_ignerr !== 1'b1) begin errors++; $display("FAIL ignerr_sticky: got %b expected 1", a_ignerr); end
    endtask

    // Corner rows of both banks and the dropped-write address all read as zero.
    task automatic test_init_reads();
        logic [12:0] av [5];
        av[0] = 13'h0000; av[1] = 13'h0FFF; av[2] = 13'h1000; av[3] = 13'h1FFF; av[4] = 13'h0005;
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, 4'h0, av[i], 32'h0);
            tick();
            drive_a(1'b0, 4'h0, 13'h0000, 32'h0);
            checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin errors++; $display("FAIL init_read[%0d]: got %h/%b expected 00000000/1", i, a_rdata, a_rvalid); end
            tick();
            checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL init_read_pulse[%0d]: got %b expected 0", i, a_rvalid); end
        end
    endtask

    task automatic test_back_to_back();
        drive_a(1'b1, 4'hF, 13'h0010, 32'hDEAD_BEEF);
        tick();
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid: got %b expected 0", a_rvalid); end
        drive_a(1'b1, 4'hF, 13'h1010, 32'hCAFE_F00D);
        tick();
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata_hold: got %h expected %h", a_rdata, 32'h0); end
        drive_a(1'b1, 4'h0, 13'h0010, 32'h0);
        tick();
        drive_a(1'b1, 4'h0, 13'h1010, 32'h0);
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_0: got %h/%b expected deadbeef/1", a_rdata, a_rvalid); end
        tick();
        drive_a(1'b1, 4'h0, 13'h0010, 32'h0);
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_1: got %h/%b expected cafef00d/1", a_rdata, a_rvalid); end
        tick();
        drive_a(1'b0, 4'h0, 13'h0000, 32'h0);
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_2: got %h/%b expected deadbeef/1", a_rdata, a_rvalid); end
        repeat (3) tick();
        checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL idle_hold: got %h/%b expected deadbeef/0", a_rdata, a_rvalid); end
    endtask

    task automatic test_byte_write();
        drive_a(1'b1, 4'hF, 13'h0020, 32'h1122_3344);
        tick();
        drive_a(1'b1, 4'b0101, 13'h0020, 32'hAABB_CCDD);
        tick();
        drive_a(1'b1, 4'h0, 13'h0020, 32'h0);
        tick();
        drive_a(1'b0, 4'h0, 13'h0000, 32'h0);
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h11BB_33DD) begin errors++; $display("FAIL byte_merge: got %h/%b expected 11bb33dd/1", a_rdata, a_rvalid); end
    endtask

    // Four-bank build with the output register: two-cycle latency and cross-bank reads.
    task automatic test_rd_pipe();
        cs_b = 1'b1; wren = 4'hF; addr = 13'h0800; wdata = 32'h5A5A_0001;
        tick();
        cs_b = 1'b1; wren = 4'hF; addr = 13'h0000; wdata = 32'h1234_5678;
        tick();
        cs_b = 1'b1; wren = 4'h0; addr = 13'h0800; wdata = 32'h0;
        tick();
        cs_b = 1'b1; wren = 4'h0; addr = 13'h0000;
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL pipe_early: got %b expected 0", b_rvalid); end
        tick();
        cs_b = 1'b0;
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h5A5A_0001) begin errors++; $display("FAIL pipe_rd0: got %h/%b expected 5a5a0001/1", b_rdata, b_rvalid); end
        tick();
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h1234_5678) begin errors++; $display("FAIL pipe_rd1: got %h/%b expected 12345678/1", b_rdata, b_rvalid); end
        repeat (4) tick();
        checks++; if (b_rvalid !== 1'b0 || b_rdata !== 32'h1234_5678) begin errors++; $display("FAIL pipe_hold: got %h/%b expected 12345678/0", b_rdata, b_rvalid); end
        checks++; if (b_ignerr !== 1'b0) begin errors++; $display("FAIL noinit_ignerr: got %b expected 0", b_ignerr); end
    endtask

    // One-cycle reset at scrub cycle 2000 clears the flag and restarts a full scrub.
    task automatic test_reset_mid_scrub();
        int n;
        rstn = 1'b0;
        drive_a(1'b0, 4'h0, 13'h0000, 32'h0);
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (k == 50) drive_a(1'b1, 4'h0, 13'h0000, 32'h0);
            else         drive_a(1'b0, 4'h0, 13'h0000, 32'h0);
            tick();
        end
        checks++; if (a_ignerr !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL mid_scrub_state: got ign=%b rdy=%b expected ign=1 rdy=0", a_ignerr, a_ready); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++; if (a_ignerr !== 1'b0) begin errors++; $display("FAIL rst_clears_ignerr: got %b expected 0", a_ignerr); end
        n = 0;
        while (a_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        checks++; if (n !== 4096) begin errors++; $display("FAIL rescrub_len: got %0d expected 4096", n); end
        drive_a(1'b1, 4'h0, 13'h0010, 32'h0);
        tick();
        drive_a(1'b0, 4'h0, 13'h0000, 32'h0);
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin errors++; $display("FAIL rescrub_zero: got %h/%b expected 00000000/1", a_rdata, a_rvalid); end
    endtask

    initial begin
        test_reset();
        test_scrub_ignore();
        test_init_reads();
        test_back_to_back();
        test_byte_write();
        test_rd_pipe();
        test_reset_mid_scrub();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
